// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state enum, opcodes
// and the datapath mux/ALU selector codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        TRAP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore-style control FSM sequencing a shared multicycle MIPS datapath, with
// memory-ready stalls and a sticky trap state for illegal opcodes.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (op_code == OP_LW || op_code == OP_SW) state_d = MEM_ADDR;
                else if (op_code == OP_RTYPE)             state_d = EXECUTE;
                else if (op_code == OP_BEQ)               state_d = BRANCH;
                else if (op_code == OP_J)                 state_d = JUMP;
                else                                      state_d = TRAP;
            end
            MEM_ADDR:  state_d = (op_code == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WB:    state_d = FETCH;
            MEM_WRITE: if (mem_ready) state_d = FETCH;
            EXECUTE:   state_d = R_WB;
            R_WB:      state_d = FETCH;
            BRANCH:    state_d = FETCH;
            JUMP:      state_d = FETCH;
            TRAP:      state_d = TRAP;
            default:   state_d = FETCH;
        endcase
    end

    // Outputs are held at zero while rst is high so an abandoned instruction
    // cannot strobe memory or the register file during the reset cycle.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        trap        = 1'b0;
        state_o     = 4'd0;
        if (!rst) begin
            state_o = state_q;
            unique case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE:    ALUSrcB = SRCB_IMMSH;
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                R_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    instr_done  = 1'b1;
                end
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                TRAP:    trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level driver builds
// the expected per-cycle output trace; a negedge monitor compares it.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] op_code;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, trap;
  logic [3:0] state_o;

  localparam int W = 22;
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .trap(trap),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done,trap,state}
  function automatic logic [W-1:0] pack(
    bit pcw, bit pcwc, bit iord, bit mrd, bit mwr, bit irw, bit m2r,
    bit rdst, bit rw, bit srca, logic [1:0] srcb, logic [1:0] aop,
    logic [1:0] pcs, bit done, bit trp, logic [3:0] st);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
            srcb, aop, pcs, done, trp, st};
  endfunction

  // Reference table of control outputs, one row per named state.
  function automatic logic [W-1:0] ref_out(int st, bit rdy);
    case (st)
      0:  return pack(rdy,0,0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00,0,0,4'd0);
      1:  return pack(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,4'd1);
      2:  return pack(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,4'd2);
      3:  return pack(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,4'd3);
      4:  return pack(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0,4'd4);
      5:  return pack(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,rdy,0,4'd5);
      6:  return pack(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,4'd6);
      7:  return pack(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0,4'd7);
      8:  return pack(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,4'd8);
      9:  return pack(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,4'd9);
      10: return pack(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,4'd10);
      default: return '0;
    endcase
  endfunction

  function automatic logic [5:0] kind_op(int k);
    case (k)
      K_R:     return 6'b000000;
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_BEQ:   return 6'b000100;
      default: return 6'b000010;
    endcase
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver tasks
  task automatic cycle(input int st, input logic [5:0] op, input bit rdy);
    rst = 1'b0;
    op_code = op;
    mem_ready = rdy;
    exp_q.push_back(ref_out(st, rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle(input logic [5:0] op, input bit rdy);
    rst = 1'b1;
    op_code = op;
    mem_ready = rdy;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input int fs);
    for (int i = 0; i < fs; i++) cycle(0, rnd_op(), 0);
    cycle(0, rnd_op(), 1);
    cycle(1, op, rnd_bit());
  endtask

  // One legal instruction: fs fetch stalls, ms memory stalls.
  task automatic run_instr(input int k, input int fs, input int ms);
    logic [5:0] op;
    op = kind_op(k);
    fetch_decode(op, fs);
    case (k)
      K_R: begin
        cycle(6, rnd_op(), rnd_bit());
        cycle(7, rnd_op(), rnd_bit());
      end
      K_LW: begin
        cycle(2, op, rnd_bit());
        for (int i = 0; i < ms; i++) cycle(3, rnd_op(), 0);
        cycle(3, rnd_op(), 1);
        cycle(4, rnd_op(), rnd_bit());
      end
      K_SW: begin
        cycle(2, op, rnd_bit());
        for (int i = 0; i < ms; i++) cycle(5, rnd_op(), 0);
        cycle(5, rnd_op(), 1);
      end
      K_BEQ: cycle(8, rnd_op(), rnd_bit());
      default: cycle(9, rnd_op(), rnd_bit());
    endcase
  endtask

  function automatic logic [5:0] illegal_op();
    logic [5:0] v;
    v = rnd_op();
    while (v == 6'b000000 || v == 6'b100011 || v == 6'b101011 ||
           v == 6'b000100 || v == 6'b000010)
      v = rnd_op();
    return v;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (chk_en) begin
      cyc++;
      got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
             trap, state_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow cycle %0d: got %h, no expectation queued", cyc, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %h expected %h (state got %0d exp %0d)",
                   cyc, got, exp, got[3:0], exp[3:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    op_code = 6'b101011;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // reset held two cycles, then R-type with no stalls
    rst_cycle(6'b101011, 1);
    rst_cycle(6'b101011, 0);
    run_instr(K_R, 0, 0);
    // lw with two MEM_READ stalls
    run_instr(K_LW, 0, 2);
    // sw then beq back to back
    run_instr(K_SW, 0, 0);
    run_instr(K_BEQ, 0, 0);
    // fetch stall of three cycles
    run_instr(K_R, 3, 0);
    // sw with stalls in MEM_WRITE
    run_instr(K_SW, 1, 2);

    // reset in the middle of a lw (during MEM_READ stall)
    fetch_decode(6'b100011, 0);
    cycle(2, 6'b100011, 0);
    cycle(3, rnd_op(), 0);
    rst_cycle(rnd_op(), 1);
    run_instr(K_J, 0, 0);

    // randomized instruction mix
    for (int n = 0; n < 60; n++) begin
      int k;
      int fs;
      int ms;
      k = $urandom_range(0, 4);
      fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(k, fs, ms);
      if ($urandom_range(0, 19) == 0) rst_cycle(rnd_op(), rnd_bit());
    end

    // j followed by an illegal opcode, sticky trap for 20 cycles
    run_instr(K_J, 0, 0);
    fetch_decode(6'b111111, 0);
    for (int i = 0; i < 20; i++) cycle(10, rnd_op(), rnd_bit());
    rst_cycle(rnd_op(), 1);
    run_instr(K_BEQ, 0, 0);

    // a random illegal opcode after a stalled fetch
    fetch_decode(illegal_op(), 2);
    for (int i = 0; i < 5; i++) cycle(10, rnd_op(), rnd_bit());
    rst_cycle(rnd_op(), 0);
    run_instr(K_LW, 0, 0);

    // let the monitor consume the final expectation
    @(negedge clk);
    chk_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d leftover expectations, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control unit: a Moore-style FSM that sequences the shared datapath (single memory, one ALU, register file) across fetch/decode/execute/memory/writeback cycles for R-type, lw, sw, beq and j. It replaces the single-cycle `main_control` decode when the processor runs in multicycle mode. It stalls on a memory-ready handshake and traps on illegal opcodes.

## Interface
Parameters: none. Opcodes are fixed constants from the package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_code  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero (beq)
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- trap  out  1  illegal opcode seen; sticky until reset
- state_o  out  4  current state encoding (debug)

## Operation
States use a 4-bit encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, TRAP=10.

Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are gated by mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by op_code:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other value -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- TRAP: trap=1, all strobes 0. Stay in TRAP until rst.

instr_done=1 in these cases:
- MEM_WB, R_WB, BRANCH, JUMP (unconditionally);
- MEM_WRITE on the cycle mem_ready=1.

op_code is sampled only in DECODE and MEM_ADDR. Changes in any other state are ignored.

## Timing
- Reset, applied on a clock edge with rst=1:
  - state loads FETCH and trap clears;
  - while rst=1, all outputs are forced to 0 and state_o=0;
  - reset asserted mid-instruction abandons that instruction with no write strobes on the following cycle.
- Output behaviour:
  - outputs are combinational from state;
  - IRWrite, PCWrite (in FETCH), the MEM_READ/MEM_WRITE exits and instr_done (in MEM_WRITE) also depend on mem_ready.
- Cycle counts with mem_ready tied to 1:
  - R-type = 4
  - lw = 5
  - sw = 4
  - beq = 3
  - j = 3
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Strobes stay asserted and stable during the stall.
- No strobe glitches across a state boundary; outputs are fully determined by the registered state plus mem_ready.

## Structure
- Shared package `multicycle_pkg`, containing:
  - `state_t` enum with the encodings above;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - ALUOp, ALUSrcB and PCSource localparams.
- Single module: state register, next-state logic and output decode in one file. No sub-module is needed.

## Test plan
- Reset: rst=1 for 2 cycles with op_code=101011 -> every output 0 and state_o=0. After release, state_o=0, MemRead=1, ALUSrcB=01.
- R-type, op_code=000000, mem_ready=1 -> state_o sequence 0,1,6,7,0. RegWrite=1 with RegDst=1 only in cycle 4. instr_done pulses once.
- lw with a stall: op_code=100011, mem_ready=0 for 2 cycles in MEM_READ -> sequence 0,1,2,3,3,3,4,0. MemRead=1, IorD=1 held stable throughout MEM_READ.
- sw then beq back to back, mem_ready=1 -> sw gives 0,1,2,5 with MemWrite=1 in exactly one cycle. beq gives 0,1,8 with PCWriteCond=1, ALUOp=01. instr_done pulses twice.
- j then illegal opcode 111111 -> j gives 0,1,9 with PCWrite=1, PCSource=10. Next DECODE goes to state 10 with trap=1 held for 20 cycles, cleared only by rst.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH -> IRWrite=0 and PCWrite=0 in those cycles. Both are 1 in the single mem_ready=1 cycle, then DECODE.
